// File: rtl/rv_encoder.sv
// ---------------------------------------------------------------------------
// rv_encoder
//   Streaming RV64IM instruction encoder. Takes one decoded instruction
//   descriptor per valid/ready handshake and emits 32-bit machine words with
//   one cycle of latency. The LI pseudo-instruction expands to one word
//   (addi) or two words (lui + addiw). Every immediate is range-checked; an
//   illegal descriptor produces a single word with out_err=1 and
//   out_insn=0, and the stream carries on.
//
//   Optional feature macro: RV_ENCODER_MEXT_EN
//     defined   -> in_op[3]=1 on R / R-W selects the M extension
//                  (funct7=0000001)
//     undefined -> any R / R-W descriptor with in_op[3]=1 is an error
//
// Ports
//   clk, reset_n          clock, asynchronous active-low reset
//   in_valid / in_ready   descriptor handshake
//   in_kind               instruction class (0..11, see kind_e)
//   in_op                 funct3 plus funct7 modifier bits
//   in_rd, in_rs1, in_rs2 register numbers
//   in_imm                immediate, absolute target (BRANCH/JAL), LI value
//   in_pc                 address of the first emitted word
//   out_valid / out_ready word handshake
//   out_insn, out_pc      encoded word and its address
//   out_err               descriptor was illegal (out_insn is 0)
// ---------------------------------------------------------------------------
module rv_encoder #(
  parameter int XLEN     = 64,
  parameter int MAX_KIND = 11
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      in_kind,
  input  logic [4:0]      in_op,
  input  logic [4:0]      in_rd,
  input  logic [4:0]      in_rs1,
  input  logic [4:0]      in_rs2,
  input  logic [XLEN-1:0] in_imm,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_insn,
  output logic [XLEN-1:0] out_pc,
  output logic            out_err
);

`ifdef RV_ENCODER_MEXT_EN
  localparam bit MEXT_EN = 1'b1;
`else
  localparam bit MEXT_EN = 1'b0;
`endif

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_OP_32  = 7'b0111011;
  localparam logic [6:0] OPC_IMM_32 = 7'b0011011;

  typedef enum logic [3:0] {
    K_R, K_I, K_LOAD, K_STORE, K_BRANCH, K_LUI,
    K_AUIPC, K_JAL, K_JALR, K_LI, K_RW, K_IW
  } kind_e;

  typedef enum logic {S_IDLE, S_EMIT2} state_e;

  state_e r_state, w_state_nxt;

  logic            r_out_valid;
  logic [31:0]     r_out_insn;
  logic [XLEN-1:0] r_out_pc;
  logic            r_out_err;
  logic [31:0]     r_word2;

  kind_e           w_kind;
  logic [2:0]      w_f3;
  logic [XLEN-1:0] w_off;
  logic [19:0]     w_li_hi;
  logic            w_kind_ok;
  logic            w_fits12, w_fits32, w_shamt6, w_shamt5, w_u20;
  logic            w_br_ok, w_jal_ok;
  logic            w_err, w_two;
  logic [31:0]     w_word1, w_word2;
  logic            w_accept, w_load2;

  assign w_kind    = kind_e'(in_kind);
  assign w_f3      = in_op[2:0];
  assign w_kind_ok = int'(in_kind) <= MAX_KIND;

  // Range checks are done on the upper bits: a value fits a signed N-bit
  // field when bits [XLEN-1:N-1] are all zeros or all ones.
  assign w_fits12 = (&in_imm[XLEN-1:11]) || ~|in_imm[XLEN-1:11];
  assign w_fits32 = (&in_imm[XLEN-1:31]) || ~|in_imm[XLEN-1:31];
  assign w_shamt6 = ~|in_imm[XLEN-1:6];
  assign w_shamt5 = ~|in_imm[XLEN-1:5];
  assign w_u20    = ~|in_imm[XLEN-1:20];

  assign w_off    = in_imm - in_pc;
  assign w_br_ok  = !w_off[0] && ((&w_off[XLEN-1:12]) || ~|w_off[XLEN-1:12]);
  assign w_jal_ok = !w_off[0] && ((&w_off[XLEN-1:20]) || ~|w_off[XLEN-1:20]);

  // hi = (imm + 0x800) >> 12 so that the addiw part, sext(imm[11:0]),
  // stays within -2048..2047.
  assign w_li_hi = in_imm[31:12] + {19'b0, in_imm[11]};

  // NOTE: every signal written here gets a default first, so no path
  // through the case can leave one unassigned and infer a latch.
  always_comb begin
    w_err   = 1'b0;
    w_two   = 1'b0;
    w_word1 = '0;
    w_word2 = '0;
    case (w_kind)
      K_R: begin
        if (in_op[3]) w_err = !MEXT_EN || in_op[4];
        else          w_err = in_op[4] && (w_f3 != 3'd0) && (w_f3 != 3'd5);
        w_word1 = {1'b0, in_op[4], 4'b0, in_op[3], in_rs2, in_rs1, w_f3, in_rd, OPC_OP};
      end
      K_RW: begin
        if (in_op[3])
          w_err = !MEXT_EN || in_op[4] || (w_f3 inside {3'd1, 3'd2, 3'd3});
        else
          w_err = !((w_f3 == 3'd0) || (w_f3 == 3'd5) || (w_f3 == 3'd1 && !in_op[4]));
        w_word1 = {1'b0, in_op[4], 4'b0, in_op[3], in_rs2, in_rs1, w_f3, in_rd, OPC_OP_32};
      end
      K_I: begin
        case (w_f3)
          3'd1: begin
            w_err   = in_op[4] || in_op[3] || !w_shamt6;
            w_word1 = {6'b0, in_imm[5:0], in_rs1, w_f3, in_rd, OPC_OP_IMM};
          end
          3'd5: begin
            w_err   = in_op[4] || !w_shamt6;
            w_word1 = {1'b0, in_op[3], 4'b0, in_imm[5:0], in_rs1, w_f3, in_rd, OPC_OP_IMM};
          end
          default: begin
            w_err   = in_op[4] || in_op[3] || !w_fits12;
            w_word1 = {in_imm[11:0], in_rs1, w_f3, in_rd, OPC_OP_IMM};
          end
        endcase
      end
      K_IW: begin
        case (w_f3)
          3'd0: begin
            w_err   = in_op[4] || in_op[3] || !w_fits12;
            w_word1 = {in_imm[11:0], in_rs1, w_f3, in_rd, OPC_IMM_32};
          end
          3'd1: begin
            w_err   = in_op[4] || in_op[3] || !w_shamt5;
            w_word1 = {7'b0, in_imm[4:0], in_rs1, w_f3, in_rd, OPC_IMM_32};
          end
          3'd5: begin
            w_err   = in_op[4] || !w_shamt5;
            w_word1 = {1'b0, in_op[3], 5'b0, in_imm[4:0], in_rs1, w_f3, in_rd, OPC_IMM_32};
          end
          default: w_err = 1'b1;
        endcase
      end
      K_LOAD: begin
        w_err   = (in_op[4:3] != 2'b00) || (w_f3 == 3'd7) || !w_fits12;
        w_word1 = {in_imm[11:0], in_rs1, w_f3, in_rd, OPC_LOAD};
      end
      K_STORE: begin
        w_err   = (in_op[4:3] != 2'b00) || w_f3[2] || !w_fits12;
        w_word1 = {in_imm[11:5], in_rs2, in_rs1, w_f3, in_imm[4:0], OPC_STORE};
      end
      K_BRANCH: begin
        w_err   = (in_op[4:3] != 2'b00) || (w_f3 inside {3'd2, 3'd3}) || !w_br_ok;
        w_word1 = {w_off[12], w_off[10:5], in_rs2, in_rs1, w_f3,
                   w_off[4:1], w_off[11], OPC_BRANCH};
      end
      K_LUI: begin
        w_err   = (in_op != 5'd0) || !w_u20;
        w_word1 = {in_imm[19:0], in_rd, OPC_LUI};
      end
      K_AUIPC: begin
        w_err   = (in_op != 5'd0) || !w_u20;
        w_word1 = {in_imm[19:0], in_rd, OPC_AUIPC};
      end
      K_JAL: begin
        w_err   = (in_op != 5'd0) || !w_jal_ok;
        w_word1 = {w_off[20], w_off[10:1], w_off[11], w_off[19:12], in_rd, OPC_JAL};
      end
      K_JALR: begin
        w_err   = (in_op != 5'd0) || !w_fits12;
        w_word1 = {in_imm[11:0], in_rs1, 3'd0, in_rd, OPC_JALR};
      end
      K_LI: begin
        w_err = in_op != 5'd0;
        if (w_fits12) begin
          w_word1 = {in_imm[11:0], 5'd0, 3'd0, in_rd, OPC_OP_IMM};
        end else if (w_fits32) begin
          w_word1 = {w_li_hi, in_rd, OPC_LUI};
          w_word2 = {in_imm[11:0], in_rd, 3'd0, in_rd, OPC_IMM_32};
          w_two   = in_imm[11:0] != 12'd0;
        end else begin
          w_err = 1'b1;
        end
      end
      default: w_err = 1'b1;
    endcase
    if (!w_kind_ok) w_err = 1'b1;
    if (w_err) begin
      w_word1 = '0;
      w_word2 = '0;
      w_two   = 1'b0;
    end
  end

  // Handshake: a new descriptor may overwrite the output register in the
  // same cycle the old word drains; EMIT2 blocks input until word 2 is out.
  always_comb begin
    in_ready = 1'b0;
    if (reset_n && r_state == S_IDLE) in_ready = !r_out_valid || out_ready;
  end

  assign w_accept = in_valid && in_ready;
  assign w_load2  = (r_state == S_EMIT2) && out_ready;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept && w_two) w_state_nxt = S_EMIT2;
      S_EMIT2: if (out_ready)         w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: r_word2 is a single holding register, not a memory, so it is
  // reset along with the rest; asserting reset in EMIT2 discards it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_out_valid <= 1'b0;
      r_out_insn  <= '0;
      r_out_pc    <= '0;
      r_out_err   <= 1'b0;
      r_word2     <= '0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_out_insn  <= w_word1;
      r_out_pc    <= in_pc;
      r_out_err   <= w_err;
      r_word2     <= w_word2;
    end else if (w_load2) begin
      r_out_insn  <= r_word2;
      r_out_pc    <= r_out_pc + XLEN'(4);
      r_out_err   <= 1'b0;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_insn  = r_out_insn;
  assign out_pc    = r_out_pc;
  assign out_err   = r_out_err;

endmodule

// File: tb/tb_rv_encoder.sv
// ---------------------------------------------------------------------------
// tb_rv_encoder
//   Directed bench for rv_encoder: a table of single-word descriptors with
//   hand-encoded expected words streamed back to back, followed by hand
//   sequences for LI expansion, backpressure and reset during EMIT2.
// ---------------------------------------------------------------------------
module tb_rv_encoder;

  localparam int XLEN = 64;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            in_valid;
  logic            in_ready;
  logic [3:0]      in_kind;
  logic [4:0]      in_op;
  logic [4:0]      in_rd, in_rs1, in_rs2;
  logic [XLEN-1:0] in_imm, in_pc;
  logic            out_valid;
  logic            out_ready;
  logic [31:0]     out_insn;
  logic [XLEN-1:0] out_pc;
  logic            out_err;

  int n_cmp  = 0;
  int n_fail = 0;

  rv_encoder #(.XLEN(XLEN), .MAX_KIND(11)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_kind  (in_kind),
    .in_op    (in_op),
    .in_rd    (in_rd),
    .in_rs1   (in_rs1),
    .in_rs2   (in_rs2),
    .in_imm   (in_imm),
    .in_pc    (in_pc),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_insn (out_insn),
    .out_pc   (out_pc),
    .out_err  (out_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (act=running exp=done)");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [3:0]      kind;
    logic [4:0]      op;
    logic [4:0]      rd, rs1, rs2;
    logic [XLEN-1:0] imm, pc;
    logic [31:0]     insn;
    logic            err;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input logic [3:0] kind, input logic [4:0] op,
                         input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [XLEN-1:0] imm,
                         input logic [XLEN-1:0] pc, input logic [31:0] insn,
                         input logic err);
    vec_t v;
    v.kind = kind; v.op = op; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
    v.imm = imm; v.pc = pc; v.insn = insn; v.err = err;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive a descriptor at posedge+1, wait (bounded) for in_ready, and
  // return at posedge+1 after the accepting edge. stalls = cycles waited.
  task automatic send(input logic [3:0] kind, input logic [4:0] op,
                      input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [XLEN-1:0] imm,
                      input logic [XLEN-1:0] pc, output int stalls);
    in_kind = kind; in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_imm = imm; in_pc = pc; in_valid = 1'b1;
    stalls = 0;
    while (!in_ready && stalls < 50) begin
      @(posedge clk); #1;
      stalls++;
    end
    if (!in_ready) check("in_ready_timeout", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic expect_out(input string name, input logic [31:0] insn,
                            input logic [XLEN-1:0] pc, input logic err);
    check({name, "_valid"}, 64'(out_valid), 64'd1);
    check({name, "_insn"},  64'(out_insn),  64'(insn));
    check({name, "_pc"},    out_pc,         pc);
    check({name, "_err"},   64'(out_err),   64'(err));
  endtask

  initial begin
    int st;
    int total_stalls;

    // add, sub, illegal R, M-extension
    add_vec(4'd0,  5'b00000, 5'd1, 5'd2, 5'd3, 64'd0, 64'h0,   32'h003100B3, 1'b0);
    add_vec(4'd0,  5'b10000, 5'd1, 5'd2, 5'd3, 64'd0, 64'h4,   32'h403100B3, 1'b0);
    add_vec(4'd0,  5'b10001, 5'd1, 5'd2, 5'd3, 64'd0, 64'h8,   32'h0,        1'b1);
    add_vec(4'd0,  5'b11000, 5'd1, 5'd2, 5'd3, 64'd0, 64'hC,   32'h0,        1'b1);
`ifdef RV_ENCODER_MEXT_EN
    add_vec(4'd0,  5'b01000, 5'd1, 5'd2, 5'd3, 64'd0, 64'h10,  32'h023100B3, 1'b0);
    add_vec(4'd10, 5'b01000, 5'd1, 5'd2, 5'd3, 64'd0, 64'h14,  32'h023100BB, 1'b0);
`else
    add_vec(4'd0,  5'b01000, 5'd1, 5'd2, 5'd3, 64'd0, 64'h10,  32'h0,        1'b1);
    add_vec(4'd10, 5'b01000, 5'd1, 5'd2, 5'd3, 64'd0, 64'h14,  32'h0,        1'b1);
`endif
    // I-ALU: addi edges, srai 63, slli 64
    add_vec(4'd1,  5'b00000, 5'd1, 5'd2, 5'd0, -64'sd1,    64'h18, 32'hFFF10093, 1'b0);
    add_vec(4'd1,  5'b00000, 5'd1, 5'd2, 5'd0, 64'd2048,   64'h1C, 32'h0,        1'b1);
    add_vec(4'd1,  5'b00000, 5'd1, 5'd2, 5'd0, -64'sd2048, 64'h20, 32'h80010093, 1'b0);
    add_vec(4'd1,  5'b01101, 5'd1, 5'd2, 5'd0, 64'd63,     64'h24, 32'h43F15093, 1'b0);
    add_vec(4'd1,  5'b00001, 5'd1, 5'd2, 5'd0, 64'd64,     64'h28, 32'h0,        1'b1);
    // I-W: slliw 31 / 32
    add_vec(4'd11, 5'b00001, 5'd1, 5'd2, 5'd0, 64'd31,     64'h2C, 32'h01F1109B, 1'b0);
    add_vec(4'd11, 5'b00001, 5'd1, 5'd2, 5'd0, 64'd32,     64'h30, 32'h0,        1'b1);
    // load / store
    add_vec(4'd2,  5'b00011, 5'd1, 5'd2, 5'd0, 64'd8,      64'h34, 32'h00813083, 1'b0);
    add_vec(4'd2,  5'b00111, 5'd1, 5'd2, 5'd0, 64'd8,      64'h38, 32'h0,        1'b1);
    add_vec(4'd3,  5'b00011, 5'd0, 5'd2, 5'd3, -64'sd8,    64'h3C, 32'hFE313C23, 1'b0);
    // branch: back 16, odd target, +4096, +4094
    add_vec(4'd4,  5'b00000, 5'd0, 5'd1, 5'd2, 64'hF0,     64'h100, 32'hFE2088E3, 1'b0);
    add_vec(4'd4,  5'b00000, 5'd0, 5'd1, 5'd2, 64'h101,    64'h100, 32'h0,        1'b1);
    add_vec(4'd4,  5'b00000, 5'd0, 5'd1, 5'd2, 64'h1100,   64'h100, 32'h0,        1'b1);
    add_vec(4'd4,  5'b00000, 5'd0, 5'd1, 5'd2, 64'h10FE,   64'h100, 32'h7E208FE3, 1'b0);
    // lui / auipc
    add_vec(4'd5,  5'b00000, 5'd5, 5'd0, 5'd0, 64'hFFFFF,  64'h104, 32'hFFFFF2B7, 1'b0);
    add_vec(4'd5,  5'b00000, 5'd5, 5'd0, 5'd0, 64'h100000, 64'h108, 32'h0,        1'b1);
    add_vec(4'd6,  5'b00000, 5'd1, 5'd0, 5'd0, 64'd1,      64'h10C, 32'h00001097, 1'b0);
    // jal: +8, -4, +1 MiB; jalr
    add_vec(4'd7,  5'b00000, 5'd1, 5'd0, 5'd0, 64'h208,    64'h200, 32'h008000EF, 1'b0);
    add_vec(4'd7,  5'b00000, 5'd1, 5'd0, 5'd0, 64'h1FC,    64'h200, 32'hFFDFF0EF, 1'b0);
    add_vec(4'd7,  5'b00000, 5'd1, 5'd0, 5'd0, 64'h100200, 64'h200, 32'h0,        1'b1);
    add_vec(4'd8,  5'b00000, 5'd1, 5'd2, 5'd0, 64'd0,      64'h204, 32'h000100E7, 1'b0);
    add_vec(4'd8,  5'b00001, 5'd1, 5'd2, 5'd0, 64'd0,      64'h208, 32'h0,        1'b1);
    // single-word LI cases and LI out of 32-bit range
    add_vec(4'd9,  5'b00000, 5'd5, 5'd0, 5'd0, -64'sd5,    64'h20C, 32'hFFB00293, 1'b0);
    add_vec(4'd9,  5'b00000, 5'd5, 5'd0, 5'd0, 64'h3000,   64'h210, 32'h000032B7, 1'b0);
    add_vec(4'd9,  5'b00000, 5'd5, 5'd0, 5'd0, 64'h1_0000_0000, 64'h214, 32'h0,   1'b1);
    // kind beyond MAX_KIND
    add_vec(4'd12, 5'b00000, 5'd1, 5'd2, 5'd3, 64'd0,      64'h218, 32'h0,        1'b1);

    // ---------------- reset state ----------------
    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_kind = '0; in_op = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
    in_imm = '0; in_pc = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_insn",  64'(out_insn),  64'd0);
    check("rst_out_pc",    out_pc,         64'd0);
    check("rst_out_err",   64'(out_err),   64'd0);
    check("rst_in_ready",  64'(in_ready),  64'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // ---------------- table, streamed back to back ----------------
    total_stalls = 0;
    foreach (vecs[i]) begin
      send(vecs[i].kind, vecs[i].op, vecs[i].rd, vecs[i].rs1, vecs[i].rs2,
           vecs[i].imm, vecs[i].pc, st);
      total_stalls += st;
      expect_out($sformatf("vec%0d", i), vecs[i].insn, vecs[i].pc, vecs[i].err);
    end
    check("throughput_stalls", 64'(total_stalls), 64'd0);
    @(posedge clk); #1;
    check("drain_valid", 64'(out_valid), 64'd0);

    // ---------------- LI two words, free-flowing ----------------
    send(4'd9, 5'd0, 5'd5, 5'd0, 5'd0, 64'h12345678, 64'h1000, st);
    expect_out("li1_w1", 32'h123452B7, 64'h1000, 1'b0);
    check("li1_emit2_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    expect_out("li1_w2", 32'h6782829B, 64'h1004, 1'b0);
    check("li1_idle_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    check("li1_done_valid", 64'(out_valid), 64'd0);

    send(4'd9, 5'd0, 5'd5, 5'd0, 5'd0, 64'h1800, 64'h2000, st);
    expect_out("li2_w1", 32'h000022B7, 64'h2000, 1'b0);
    @(posedge clk); #1;
    expect_out("li2_w2", 32'h8002829B, 64'h2004, 1'b0);
    @(posedge clk); #1;
    check("li2_done_valid", 64'(out_valid), 64'd0);

    // ---------------- backpressure during LI word 1 ----------------
    out_ready = 1'b0;
    send(4'd9, 5'd0, 5'd5, 5'd0, 5'd0, 64'h12345678, 64'h3000, st);
    expect_out("bp_w1", 32'h123452B7, 64'h3000, 1'b0);
    // offer an add while stalled; it must not be taken
    in_kind = 4'd0; in_op = 5'd0; in_rd = 5'd1; in_rs1 = 5'd2; in_rs2 = 5'd3;
    in_imm = '0; in_pc = 64'h4000; in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      expect_out($sformatf("bp_hold%0d", c), 32'h123452B7, 64'h3000, 1'b0);
      check($sformatf("bp_hold%0d_in_ready", c), 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    expect_out("bp_w2", 32'h6782829B, 64'h3004, 1'b0);
    check("bp_w2_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    expect_out("bp_add", 32'h003100B3, 64'h4000, 1'b0);
    @(posedge clk); #1;
    check("bp_done_valid", 64'(out_valid), 64'd0);

    // ---------------- reset asserted in EMIT2 ----------------
    out_ready = 1'b0;
    send(4'd9, 5'd0, 5'd5, 5'd0, 5'd0, 64'h12345678, 64'h5000, st);
    expect_out("rst2_w1", 32'h123452B7, 64'h5000, 1'b0);
    reset_n = 1'b0;
    #1;
    check("rst2_valid_now", 64'(out_valid), 64'd0);
    check("rst2_in_ready",  64'(in_ready),  64'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      check($sformatf("rst2_no_w2_%0d", c), 64'(out_valid), 64'd0);
    end
    send(4'd0, 5'd0, 5'd1, 5'd2, 5'd3, 64'd0, 64'h6000, st);
    expect_out("rst2_after", 32'h003100B3, 64'h6000, 1'b0);
    @(posedge clk); #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/rv_encoder.md
Name: rv_encoder

Overview:
- Streaming RV64IM instruction encoder (assembler back end) for the disassembly/test-generation environment.
- Accepts one decoded instruction descriptor per handshake and emits 32-bit machine words.
- Descriptor carries kind, op select, register numbers, immediate/target and pc.
- Expands the LI pseudo-instruction into 1 or 2 words and range-checks all immediates.
- Feeds instruction memory images and round-trip checks against the disassembler.

Parameters:
XLEN, 64, width of pc and immediate/target fields
MAX_KIND, 11, highest legal in_kind code; larger codes are errors

Ports:
clk  in  1  single clock, all state on rising edge
reset_n  in  1  asynchronous, active-low reset
in_valid  in  1  descriptor valid
in_ready  out  1  encoder can accept descriptor
in_kind  in  4  0=R 1=I-ALU 2=LOAD 3=STORE 4=BRANCH 5=LUI 6=AUIPC 7=JAL 8=JALR 9=LI 10=R-W(0111011) 11=I-W(0011011)
in_op  in  5  R/R-W: {insn[30],insn[25],funct3}; I-ALU/I-W: {1'b0,insn[30],funct3}; others: {2'b0,funct3}
in_rd  in  5  destination register
in_rs1  in  5  source 1
in_rs2  in  5  source 2
in_imm  in  XLEN  signed immediate; absolute target address for BRANCH/JAL; value for LI
in_pc  in  XLEN  address of the (first) emitted word
out_valid  out  1  word valid
out_ready  in  1  downstream accepts word
out_insn  out  32  encoded word
out_pc  out  XLEN  address of out_insn
out_err  out  1  descriptor illegal; out_insn forced to 32'h0

Behaviour:
- Reset: out_valid=0, out_insn=0, out_pc=0, out_err=0, FSM=IDLE, in_ready=0 while reset_n low.
- FSM states:
  - IDLE: in_ready = !out_valid || out_ready. Descriptor accepted on in_valid && in_ready; out_* registered next cycle (latency 1).
  - LI with two words: IDLE -> EMIT2 after the first word is loaded.
  - EMIT2: in_ready=0. On out_ready with out_valid, load the second word at out_pc+4, then return to IDLE.
- Full throughput: back-to-back single-word descriptors, one per cycle, when out_ready is held high.
- Backpressure: out_valid && !out_ready holds all out_* stable.
- Immediate rules:
  - I-type, load, JALR, addi/addiw need -2048..2047.
  - STORE needs -2048..2047, split {imm[11:5], imm[4:0]}.
  - Shifts: I-ALU shamt 0..63 (insn[25:20]); I-W shamt 0..31.
  - LUI/AUIPC take in_imm[19:0]; in_imm must be within 0..0xFFFFF.
  - BRANCH: off = in_imm - in_pc; must be even and within -4096..4094.
  - JAL: off = in_imm - in_pc; must be even and within ±1 MiB.
  - Any violation sets out_err=1 and out_insn=0; the pipeline continues.
- Illegal op/kind combinations set out_err: undefined funct3 for the kind; in_op[4] or in_op[3] set where unused; kind > MAX_KIND.
- LI expansion:
  - imm within -2048..2047: one word, addi rd,x0,imm.
  - Else imm within signed 32-bit: hi=(imm+0x800)>>12 (20-bit), lo=imm-(hi<<12).
    - Word 1: lui rd,hi.
    - Word 2: addiw rd,rd,lo. Omitted if lo==0.
  - Else out_err on a single word.
- Simultaneous load and drain in IDLE is allowed; no bubble.
- Reset asserted mid-EMIT2 discards the pending second word.

Optional Feature:
- Macro RV_ENCODER_MEXT_EN.
- Defined: in_op[3]=1 with funct7=0000001 legal for R (mul..remu) and R-W (mulw, divw, divuw, remw, remuw).
- Undefined: any R/R-W descriptor with in_op[3]=1 gives out_err=1, out_insn=0.

Test Plan:
- add x1,x2,x3 (kind0, op 0, pc 0x0) -> out_insn 0x003100B3, out_err 0, one cycle after accept.
- LI x5,0x12345678, pc 0x1000 -> 0x123452B7 @0x1000, then 0x6782829B @0x1004; in_ready low in EMIT2.
- LI x5,0x1800 -> 0x000022B7 then 0x8002829B (lo=-2048); LI x5,0x3000 -> single word 0x000032B7.
- beq x1,x2, pc 0x100, target 0xF0 -> 0xFE2088E3; target 0x101 -> out_err 1, out_insn 0; target pc+4096 -> out_err.
- Hold out_ready low 5 cycles during LI word 1 -> outputs stable, no descriptor accepted; release -> word 2 follows.
- Assert reset_n low in EMIT2 -> out_valid 0 within the cycle, no second word after release; mul x1,x2,x3 -> 0x023100B3 with RV_ENCODER_MEXT_EN, out_err without.
